// File: rtl/hpu_ctrl_regs.sv
// hpu_ctrl_regs: AXI-Lite control/status register block for the HPU.
//
// Terminates the host AXI-Lite slave port and holds the datapath
// configuration (run/gen, N-gram, per-core address count, remainder,
// item-memory count). It also drives the item-memory generation counter,
// and gen clears itself when the counter reaches the item count. Writes
// honour byte strobes, and unmapped accesses answer SLVERR. STATUS bits are
// sticky and write-1-to-clear. A saturating counter counts the cycles in
// which run is high.
//
// Optional feature: define HPU_CTRL_IRQ_EN to add the IRQ_EN register at
// 0x1C and the level interrupt output irq.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   S_AXI_*            AXI-Lite slave (AW/W/B write, AR/R read channels)
//   get_fin            one-cycle pulse when a job's input is consumed
//   run, gen           datapath mode bits
//   addr_j, addr_i     N-gram register, address count per core
//   remainder          remainder register
//   item_memory_num    item-memory count register
//   item_a             item-memory generation index
//   item_last          high while gen=1 and item_a==item_memory_num
//   irq                level interrupt (HPU_CTRL_IRQ_EN only)
module hpu_ctrl_regs #(
  parameter int ADDR_W  = 12,
  parameter int CNT_W   = 16,
  parameter int ADDRJ_W = 20,
  parameter int ADDRI_W = 20,
  parameter int REM_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  S_AXI_AWADDR,
  input  logic               S_AXI_AWVALID,
  output logic               S_AXI_AWREADY,
  input  logic [31:0]        S_AXI_WDATA,
  input  logic [3:0]         S_AXI_WSTRB,
  input  logic               S_AXI_WVALID,
  output logic               S_AXI_WREADY,
  output logic [1:0]         S_AXI_BRESP,
  output logic               S_AXI_BVALID,
  input  logic               S_AXI_BREADY,
  input  logic [ADDR_W-1:0]  S_AXI_ARADDR,
  input  logic               S_AXI_ARVALID,
  output logic               S_AXI_ARREADY,
  output logic [31:0]        S_AXI_RDATA,
  output logic [1:0]         S_AXI_RRESP,
  output logic               S_AXI_RVALID,
  input  logic               S_AXI_RREADY,
  input  logic               get_fin,
  output logic               run,
  output logic               gen,
  output logic [ADDRJ_W-1:0] addr_j,
  output logic [ADDRI_W-1:0] addr_i,
  output logic [REM_W-1:0]   remainder,
  output logic [CNT_W-1:0]   item_memory_num,
  output logic [CNT_W-1:0]   item_a,
  output logic               item_last
`ifdef HPU_CTRL_IRQ_EN
  ,
  output logic               irq
`endif
);

`ifdef HPU_CTRL_IRQ_EN
  localparam logic [2:0] LAST_WORD = 3'd7;
`else
  localparam logic [2:0] LAST_WORD = 3'd6;
`endif
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR1  = 3'd4,
    ST_AR2  = 3'd5
  } state_t;

  // Mapped means: inside the 32-byte register window and not past the last implemented word.
  function automatic logic addr_mapped(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a >> 2;
    addr_mapped = ((off >> 3) == {ADDR_W{1'b0}}) && (off[2:0] <= LAST_WORD);
  endfunction

  // Byte-lane merge of new write data into an old register value.
  function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] mask;
    for (int k = 0; k < 4; k++) begin
      mask[8*k +: 8] = {8{strb[k]}};
    end
    lane_merge = (old & ~mask) | (data & mask);
  endfunction

  state_t            state_r;
  logic [ADDR_W-1:0] awaddr_r;
  logic [ADDR_W-1:0] araddr_r;
  logic [31:0]       wdata_r;
  logic [3:0]        wstrb_r;
  logic              wr_pend_r;   // high only during the first cycle in B
  logic [1:0]        status_r;
  logic [31:0]       cycles_r;
`ifdef HPU_CTRL_IRQ_EN
  logic [1:0]        irq_en_r;
`endif

  logic              wr_en_s;
  logic [2:0]        wr_word_s;
  logic              ctrl_we_s;
  logic              gen_hit_s;
  logic              run_rise_s;
  logic [1:0]        status_clr_s;
  logic [31:0]       rd_data_s;
  logic              rd_ok_s;

  // Write decode, generation-counter terminal detect and read mux.
  always_comb begin
    wr_en_s      = wr_pend_r && addr_mapped(awaddr_r);
    wr_word_s    = awaddr_r[4:2];
    ctrl_we_s    = wr_en_s && (wr_word_s == 3'd0) && wstrb_r[0];
    run_rise_s   = ctrl_we_s && wdata_r[1] && !run;
    gen_hit_s    = gen && (item_a == item_memory_num);
    if (wr_en_s && (wr_word_s == 3'd5) && wstrb_r[0]) begin
      status_clr_s = wdata_r[1:0];
    end else begin
      status_clr_s = 2'b00;
    end
    rd_ok_s   = addr_mapped(araddr_r);
    rd_data_s = 32'd0;
    if (rd_ok_s) begin
      case (araddr_r[4:2])
        3'd0:    rd_data_s = {30'd0, run, gen};
        3'd1:    rd_data_s = 32'(addr_j);
        3'd2:    rd_data_s = 32'(addr_i);
        3'd3:    rd_data_s = 32'(remainder);
        3'd4:    rd_data_s = 32'(item_memory_num);
        3'd5:    rd_data_s = {30'd0, status_r};
        3'd6:    rd_data_s = cycles_r;
`ifdef HPU_CTRL_IRQ_EN
        3'd7:    rd_data_s = {30'd0, irq_en_r};
`endif
        default: rd_data_s = 32'd0;
      endcase
    end else begin
      rd_data_s = 32'd0;
    end
  end

  assign item_last = gen_hit_s;

  // AXI-Lite handshake FSM with registered ready/valid/response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      S_AXI_AWREADY <= 1'b1;
      S_AXI_WREADY  <= 1'b1;
      S_AXI_ARREADY <= 1'b1;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= 32'd0;
      awaddr_r      <= {ADDR_W{1'b0}};
      araddr_r      <= {ADDR_W{1'b0}};
      wdata_r       <= 32'd0;
      wstrb_r       <= 4'd0;
      wr_pend_r     <= 1'b0;
    end else begin
      wr_pend_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            awaddr_r      <= S_AXI_AWADDR;
            wdata_r       <= S_AXI_WDATA;
            wstrb_r       <= S_AXI_WSTRB;
            S_AXI_BRESP   <= addr_mapped(S_AXI_AWADDR) ? RESP_OKAY : RESP_SLVERR;
            state_r       <= ST_B;
            S_AXI_BVALID  <= 1'b1;
            wr_pend_r     <= 1'b1;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
          end else if (S_AXI_AWVALID) begin
            awaddr_r      <= S_AXI_AWADDR;
            state_r       <= ST_AW;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
          end else if (S_AXI_WVALID) begin
            wdata_r       <= S_AXI_WDATA;
            wstrb_r       <= S_AXI_WSTRB;
            state_r       <= ST_W;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
          end else if (S_AXI_ARVALID) begin
            araddr_r      <= S_AXI_ARADDR;
            state_r       <= ST_AR1;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_AW: begin
          if (S_AXI_WVALID) begin
            wdata_r      <= S_AXI_WDATA;
            wstrb_r      <= S_AXI_WSTRB;
            S_AXI_BRESP  <= addr_mapped(awaddr_r) ? RESP_OKAY : RESP_SLVERR;
            state_r      <= ST_B;
            S_AXI_BVALID <= 1'b1;
            wr_pend_r    <= 1'b1;
            S_AXI_WREADY <= 1'b0;
          end else begin
            state_r <= ST_AW;
          end
        end
        ST_W: begin
          if (S_AXI_AWVALID) begin
            awaddr_r      <= S_AXI_AWADDR;
            S_AXI_BRESP   <= addr_mapped(S_AXI_AWADDR) ? RESP_OKAY : RESP_SLVERR;
            state_r       <= ST_B;
            S_AXI_BVALID  <= 1'b1;
            wr_pend_r     <= 1'b1;
            S_AXI_AWREADY <= 1'b0;
          end else begin
            state_r <= ST_W;
          end
        end
        ST_B: begin
          if (S_AXI_BREADY) begin
            state_r       <= ST_IDLE;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            S_AXI_ARREADY <= 1'b1;
          end else begin
            state_r <= ST_B;
          end
        end
        ST_AR1: begin
          S_AXI_RDATA  <= rd_data_s;
          S_AXI_RRESP  <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
          S_AXI_RVALID <= 1'b1;
          state_r      <= ST_AR2;
        end
        ST_AR2: begin
          if (S_AXI_RREADY) begin
            state_r       <= ST_IDLE;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            S_AXI_ARREADY <= 1'b1;
          end else begin
            state_r <= ST_AR2;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          S_AXI_BVALID  <= 1'b0;
          S_AXI_RVALID  <= 1'b0;
          S_AXI_AWREADY <= 1'b1;
          S_AXI_WREADY  <= 1'b1;
          S_AXI_ARREADY <= 1'b1;
        end
      endcase
    end
  end

  // Register file, generation counter, sticky status, cycle counter and irq.
  always_ff @(posedge clk) begin
    if (rst) begin
      run             <= 1'b0;
      gen             <= 1'b0;
      addr_j          <= {ADDRJ_W{1'b0}};
      addr_i          <= {ADDRI_W{1'b0}};
      remainder       <= {REM_W{1'b0}};
      item_memory_num <= {CNT_W{1'b0}};
      item_a          <= {CNT_W{1'b0}};
      status_r        <= 2'b00;
      cycles_r        <= 32'd0;
`ifdef HPU_CTRL_IRQ_EN
      irq_en_r        <= 2'b00;
      irq             <= 1'b0;
`endif
    end else begin
      // An explicit CTRL write takes priority over the gen auto-clear.
      if (ctrl_we_s) begin
        gen <= wdata_r[0];
        run <= wdata_r[1];
      end else if (gen_hit_s) begin
        gen <= 1'b0;
      end else begin
        gen <= gen;
      end
      if (wr_en_s) begin
        case (wr_word_s)
          3'd1:    addr_j          <= ADDRJ_W'(lane_merge(32'(addr_j), wdata_r, wstrb_r));
          3'd2:    addr_i          <= ADDRI_W'(lane_merge(32'(addr_i), wdata_r, wstrb_r));
          3'd3:    remainder       <= REM_W'(lane_merge(32'(remainder), wdata_r, wstrb_r));
          3'd4:    item_memory_num <= CNT_W'(lane_merge(32'(item_memory_num), wdata_r, wstrb_r));
`ifdef HPU_CTRL_IRQ_EN
          3'd7:    irq_en_r        <= 2'(lane_merge({30'd0, irq_en_r}, wdata_r, wstrb_r));
`endif
          default: ;
        endcase
      end
      // Set terms are OR-ed after the clear so a same-cycle set wins.
      status_r <= (status_r & ~status_clr_s) | {get_fin, gen_hit_s};
      item_a   <= gen ? (item_a + CNT_W'(1)) : {CNT_W{1'b0}};
      if (run_rise_s) begin
        cycles_r <= 32'd0;
      end else if (run && (cycles_r != 32'hFFFF_FFFF)) begin
        cycles_r <= cycles_r + 32'd1;
      end else begin
        cycles_r <= cycles_r;
      end
`ifdef HPU_CTRL_IRQ_EN
      irq <= |(status_r & irq_en_r);
`endif
    end
  end

endmodule
